// File: rtl/i2c_slave_ram_rw_if.sv
// Bus bundle for i2c_slave_ram_rw: 3-wire internal I2C side plus the user RAM port.
// The wp signal is present only when I2C_RAM_WP_EN is defined.
interface i2c_slave_ram_rw_if #(
    parameter int unsigned ADDR_WIDTH = 5
) ();
    logic                  scl;
    logic                  sda_in;
    logic                  sda_out;
    logic [ADDR_WIDTH-1:0] user_addr;
    logic [7:0]            user_data;
    logic                  wr_strobe;
    logic [ADDR_WIDTH-1:0] wr_addr;
`ifdef I2C_RAM_WP_EN
    logic                  wp;
`endif

    modport slave (
        input  scl, sda_in, user_addr,
`ifdef I2C_RAM_WP_EN
        input  wp,
`endif
        output sda_out, user_data, wr_strobe, wr_addr
    );

    modport master (
        output scl, sda_in, user_addr,
`ifdef I2C_RAM_WP_EN
        output wp,
`endif
        input  sda_out, user_data, wr_strobe, wr_addr
    );
endinterface

// File: rtl/i2c_slave_ram_rw.sv
// I2C slave RAM (2^ADDR_WIDTH bytes) with EEPROM-style auto-incrementing pointer.
// Optional write protect input enabled by defining I2C_RAM_WP_EN.
module i2c_slave_ram_rw #(
    parameter logic [6:0]  I2C_ADDRESS = 7'h00,
    parameter int unsigned ADDR_WIDTH  = 5
) (
    input  logic              clk,
    input  logic              reset,
    i2c_slave_ram_rw_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE, S_DEV_ADDR, S_MEM_ADDR, S_WR_DATA, S_RD_DATA, S_RD_WAIT
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            shreg_q, shreg_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic                  sda_out_q, sda_out_d;
    logic                  wr_strobe_q, wr_strobe_d;
    logic                  ack_q, ack_d;
    logic                  load_q, load_d;
    logic                  scl_q, sda_q;
    logic [7:0]            mem_q [DEPTH];

    logic                  mem_we_c, wp_c;
    logic                  scl_rise_c, scl_fall_c, start_c, stop_c;
    logic [7:0]            byte_c;

`ifdef I2C_RAM_WP_EN
    assign wp_c = bus.wp;
`else
    assign wp_c = 1'b0;
`endif

    // Bus condition detection against the previous-cycle line levels
    assign scl_rise_c = bus.scl & ~scl_q;
    assign scl_fall_c = ~bus.scl & scl_q;
    assign start_c    = bus.scl & scl_q & sda_q & ~bus.sda_in;
    assign stop_c     = bus.scl & scl_q & ~sda_q & bus.sda_in;
    assign byte_c     = {shreg_q[6:0], bus.sda_in};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        ptr_d       = ptr_q;
        wr_addr_d   = wr_addr_q;
        sda_out_d   = sda_out_q;
        wr_strobe_d = 1'b0;
        ack_d       = ack_q;
        load_d      = load_q;
        mem_we_c    = 1'b0;

        // Pointer advances the cycle after a committed host write
        if (wr_strobe_q) ptr_d = ptr_q + 1'b1;

        if (start_c) begin
            state_d   = S_DEV_ADDR;
            bit_cnt_d = 4'd0;
            sda_out_d = 1'b1;
            load_d    = 1'b0;
        end else if (stop_c) begin
            state_d   = S_IDLE;
            sda_out_d = 1'b1;
            load_d    = 1'b0;
        end else begin
            unique case (state_q)
                S_DEV_ADDR, S_MEM_ADDR, S_WR_DATA: begin
                    // bit_cnt 8: byte received, 9: ACK slot being driven
                    if (scl_rise_c && bit_cnt_q < 4'd8) begin
                        shreg_d   = byte_c;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            ack_d = 1'b1;
                            if (state_q == S_DEV_ADDR && byte_c[7:1] != I2C_ADDRESS) begin
                                state_d = S_IDLE;
                            end else if (state_q == S_MEM_ADDR) begin
                                ptr_d = byte_c[ADDR_WIDTH-1:0];
                            end else if (state_q == S_WR_DATA) begin
                                if (wp_c) begin
                                    ack_d = 1'b0;
                                end else begin
                                    mem_we_c    = 1'b1;
                                    wr_strobe_d = 1'b1;
                                    wr_addr_d   = ptr_q;
                                end
                            end
                        end
                    end else if (scl_fall_c && bit_cnt_q == 4'd8) begin
                        sda_out_d = ~ack_q;
                        bit_cnt_d = 4'd9;
                    end else if (scl_fall_c && bit_cnt_q == 4'd9) begin
                        sda_out_d = 1'b1;
                        bit_cnt_d = 4'd0;
                        if (state_q == S_DEV_ADDR) begin
                            if (shreg_q[0]) begin
                                state_d = S_RD_DATA;
                                load_d  = 1'b1;
                            end else begin
                                state_d = S_MEM_ADDR;
                            end
                        end else begin
                            state_d = S_WR_DATA;
                        end
                    end
                end
                S_RD_DATA: begin
                    if (load_q && !bus.scl) begin
                        shreg_d   = mem_q[ptr_q];
                        sda_out_d = mem_q[ptr_q][7];
                        load_d    = 1'b0;
                        bit_cnt_d = 4'd0;
                    end else if (scl_rise_c) begin
                        if (bit_cnt_q == 4'd8) begin
                            if (!bus.sda_in) begin
                                ptr_d     = ptr_q + 1'b1;
                                load_d    = 1'b1;
                                bit_cnt_d = 4'd0;
                            end else begin
                                state_d   = S_RD_WAIT;
                                sda_out_d = 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end else if (scl_fall_c) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_out_d = 1'b1;
                        end else begin
                            sda_out_d = shreg_q[6];
                            shreg_d   = {shreg_q[6:0], 1'b0};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 4'd0;
            shreg_q     <= 8'd0;
            ptr_q       <= '0;
            wr_addr_q   <= '0;
            sda_out_q   <= 1'b1;
            wr_strobe_q <= 1'b0;
            ack_q       <= 1'b0;
            load_q      <= 1'b0;
            // Cleared so a line held low at reset release is not taken as START
            scl_q       <= 1'b0;
            sda_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            ptr_q       <= ptr_d;
            wr_addr_q   <= wr_addr_d;
            sda_out_q   <= sda_out_d;
            wr_strobe_q <= wr_strobe_d;
            ack_q       <= ack_d;
            load_q      <= load_d;
            scl_q       <= bus.scl;
            sda_q       <= bus.sda_in;
        end
    end

    // RAM contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we_c) mem_q[ptr_q] <= byte_c;
    end

    assign bus.user_data = mem_q[bus.user_addr];
    assign bus.sda_out   = sda_out_q;
    assign bus.wr_strobe = wr_strobe_q;
    assign bus.wr_addr   = wr_addr_q;
endmodule

// File: tb/tb_i2c_slave_ram_rw.sv
// Directed bench for i2c_slave_ram_rw: bit-banged I2C master with wired-AND SDA.
module tb_i2c_slave_ram_rw;
    logic       clk = 1'b0;
    logic       reset;
    logic       m_scl, m_sda;
    logic [4:0] u_addr;
`ifdef I2C_RAM_WP_EN
    logic       m_wp;
`endif
    int         n_checks = 0;
    int         n_fail = 0;
    int         strobe_cnt = 0;
    int         low_cnt = 0;
    logic [4:0] strobe_addr [$];

    i2c_slave_ram_rw_if #(.ADDR_WIDTH(5)) bus ();

    assign bus.scl       = m_scl;
    assign bus.sda_in    = m_sda & bus.sda_out;
    assign bus.user_addr = u_addr;
`ifdef I2C_RAM_WP_EN
    assign bus.wp        = m_wp;
`endif

    i2c_slave_ram_rw #(.I2C_ADDRESS(7'h00), .ADDR_WIDTH(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.wr_strobe === 1'b1) begin
            strobe_cnt++;
            strobe_addr.push_back(bus.wr_addr);
        end
        if (bus.sda_out !== 1'b1) low_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; tick(2);
        m_scl = 1'b1; tick(4);
        m_sda = 1'b0; tick(4);
        m_scl = 1'b0; tick(4);
    endtask

    task automatic i2c_stop();
        m_scl = 1'b0; tick(2);
        m_sda = 1'b0; tick(4);
        m_scl = 1'b1; tick(4);
        m_sda = 1'b1; tick(4);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            m_sda = b[i]; tick(4);
            m_scl = 1'b1; tick(4);
            m_scl = 1'b0;
        end
        m_sda = 1'b1; tick(4);
        m_scl = 1'b1; tick(2);
        ack = bus.sda_in; tick(2);
        m_scl = 1'b0; tick(4);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d, output logic released);
        m_sda = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            tick(4);
            m_scl = 1'b1; tick(2);
            d[i] = bus.sda_in; tick(2);
            m_scl = 1'b0;
        end
        m_sda = mack; tick(4);
        m_scl = 1'b1; tick(2);
        released = bus.sda_out; tick(2);
        m_scl = 1'b0; tick(1);
        m_sda = 1'b1; tick(3);
    endtask

    task automatic check_mem(input logic [4:0] a, input logic [7:0] exp, input string name);
        u_addr = a; #1;
        n_checks++;
        if (bus.user_data !== exp) begin
            n_fail++;
            $display("FAIL %s: mem[%0d] got %h expected %h", name, a, bus.user_data, exp);
        end
    endtask

    task automatic check_bit(input logic got, input logic exp, input string name);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; m_scl = 1'b1; m_sda = 1'b1; u_addr = '0;
`ifdef I2C_RAM_WP_EN
        m_wp = 1'b0;
`endif
        tick(3);
        n_checks++;
        if (bus.sda_out !== 1'b1 || bus.wr_strobe !== 1'b0 || bus.wr_addr !== 5'd0) begin
            n_fail++;
            $display("FAIL reset: sda_out=%b wr_strobe=%b wr_addr=%0d expected 1 0 0",
                     bus.sda_out, bus.wr_strobe, bus.wr_addr);
        end
        reset = 1'b0; tick(2);
    endtask

    task automatic test_write();
        logic a0, a1, a2, a3;
        int   base = strobe_cnt;
        i2c_start();
        write_byte(8'h00, a0); write_byte(8'h03, a1);
        write_byte(8'hA5, a2); write_byte(8'h5A, a3);
        i2c_stop();
        check_bit(a0, 1'b0, "write_ack_dev");
        check_bit(a1, 1'b0, "write_ack_ptr");
        check_bit(a2, 1'b0, "write_ack_d0");
        check_bit(a3, 1'b0, "write_ack_d1");
        check_mem(5'd3, 8'hA5, "write_mem3");
        check_mem(5'd4, 8'h5A, "write_mem4");
        n_checks++;
        if (strobe_cnt - base != 2) begin
            n_fail++;
            $display("FAIL write_strobes: got %0d expected 2", strobe_cnt - base);
        end else begin
            n_checks++;
            if (strobe_addr[base] !== 5'd3 || strobe_addr[base+1] !== 5'd4) begin
                n_fail++;
                $display("FAIL write_addrs: got %0d,%0d expected 3,4",
                         strobe_addr[base], strobe_addr[base+1]);
            end
        end
    endtask

    task automatic test_readback();
        logic       a0, a1, a2, r0, r1;
        logic [7:0] d0, d1;
        i2c_start();
        write_byte(8'h00, a0); write_byte(8'h03, a1);
        i2c_start();
        write_byte(8'h01, a2);
        read_byte(1'b0, d0, r0);
        read_byte(1'b1, d1, r1);
        check_bit(bus.sda_out, 1'b1, "read_release_after_nack");
        i2c_stop();
        check_bit(a2, 1'b0, "read_ack_dev");
        n_checks++;
        if (d0 !== 8'hA5 || d1 !== 8'h5A) begin
            n_fail++;
            $display("FAIL read_data: got %h,%h expected a5,5a", d0, d1);
        end
        check_bit(r0, 1'b1, "read_release_ack_slot0");
        check_bit(r1, 1'b1, "read_release_ack_slot1");
    endtask

    task automatic test_wrap();
        logic       a, r;
        logic [7:0] d;
        int         base;
        i2c_start();
        write_byte(8'h00, a); write_byte(8'h01, a); write_byte(8'hC3, a);
        i2c_stop();
        base = strobe_cnt;
        i2c_start();
        write_byte(8'h00, a); write_byte(8'h1F, a);
        write_byte(8'h11, a); write_byte(8'h22, a);
        i2c_stop();
        check_mem(5'd31, 8'h11, "wrap_mem31");
        check_mem(5'd0, 8'h22, "wrap_mem0");
        n_checks++;
        if (strobe_cnt - base != 2 || strobe_addr[base] !== 5'd31 || strobe_addr[base+1] !== 5'd0) begin
            n_fail++;
            $display("FAIL wrap_strobes: count %0d expected 2 with addrs 31,0", strobe_cnt - base);
        end
        i2c_start();
        write_byte(8'h01, a);
        read_byte(1'b1, d, r);
        i2c_stop();
        n_checks++;
        if (d !== 8'hC3) begin
            n_fail++;
            $display("FAIL wrap_current_read: got %h expected c3", d);
        end
    endtask

    task automatic test_foreign();
        logic a0, a1;
        int   sb = strobe_cnt;
        int   lb = low_cnt;
        i2c_start();
        write_byte(8'hA0, a0); write_byte(8'h12, a1);
        i2c_stop();
        check_bit(a0, 1'b1, "foreign_nack");
        n_checks++;
        if (low_cnt != lb || strobe_cnt != sb) begin
            n_fail++;
            $display("FAIL foreign_quiet: sda low cycles %0d strobes %0d expected 0 0",
                     low_cnt - lb, strobe_cnt - sb);
        end
    endtask

    task automatic test_reset_mid_read();
        logic       a, r;
        logic [7:0] d;
        int         sb, lb;
        i2c_start();
        write_byte(8'h01, a);
        m_sda = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(4); m_scl = 1'b1; tick(4); m_scl = 1'b0;
        end
        tick(4);
        check_bit(bus.sda_out, 1'b0, "midread_driving_bit4");
        m_scl = 1'b1; tick(2);
        reset = 1'b1; tick(1);
        check_bit(bus.sda_out, 1'b1, "midread_reset_release");
        reset = 1'b0;
        sb = strobe_cnt; lb = low_cnt;
        tick(1); m_scl = 1'b0;
        for (int i = 0; i < 6; i++) begin
            m_sda = i[0]; tick(4); m_scl = 1'b1; tick(4); m_scl = 1'b0;
        end
        m_sda = 1'b1; tick(4);
        n_checks++;
        if (low_cnt != lb || strobe_cnt != sb) begin
            n_fail++;
            $display("FAIL midread_ignored: sda low cycles %0d strobes %0d expected 0 0",
                     low_cnt - lb, strobe_cnt - sb);
        end
        i2c_stop();
        i2c_start();
        write_byte(8'h01, a);
        read_byte(1'b1, d, r);
        i2c_stop();
        n_checks++;
        if (d !== 8'h22) begin
            n_fail++;
            $display("FAIL midread_ptr_reset: got %h expected 22", d);
        end
    endtask

`ifdef I2C_RAM_WP_EN
    task automatic test_write_protect();
        logic       a0, a1, a2, r;
        logic [7:0] d;
        int         sb;
        i2c_start();
        write_byte(8'h00, a0); write_byte(8'h02, a0); write_byte(8'h99, a0);
        i2c_stop();
        sb = strobe_cnt;
        m_wp = 1'b1;
        i2c_start();
        write_byte(8'h00, a0); write_byte(8'h02, a1); write_byte(8'h77, a2);
        i2c_stop();
        m_wp = 1'b0;
        check_bit(a0, 1'b0, "wp_ack_dev");
        check_bit(a1, 1'b0, "wp_ack_ptr");
        check_bit(a2, 1'b1, "wp_nack_data");
        check_mem(5'd2, 8'h99, "wp_mem2");
        n_checks++;
        if (strobe_cnt != sb) begin
            n_fail++;
            $display("FAIL wp_strobe: got %0d expected 0", strobe_cnt - sb);
        end
        i2c_start();
        write_byte(8'h01, a0);
        read_byte(1'b1, d, r);
        i2c_stop();
        n_checks++;
        if (d !== 8'h99) begin
            n_fail++;
            $display("FAIL wp_ptr_unchanged: got %h expected 99", d);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_readback();
        test_wrap();
        test_foreign();
        test_reset_mid_read();
`ifdef I2C_RAM_WP_EN
        test_write_protect();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
